// File: rtl/qbuff_pkg.sv
// Shared types and default geometry for the qbuff stream loader.
// Package items are the single source of default lane count, sample width and depth.
package qbuff_pkg;

    localparam int SAMPLE_W  = 8;
    localparam int NUM_LANES = 4;
    localparam int ADDR_W    = 4;
    localparam int LANE_W    = $clog2(NUM_LANES);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    typedef logic [NUM_LANES-1:0][SAMPLE_W-1:0] lane_word_t;

endpackage

// File: rtl/qbuff_loader_if.sv
// Sample stream in and lane-memory write port out, bundled for the loader.
// master is the stream source / memory observer side, slave is the loader.
interface qbuff_loader_if
    import qbuff_pkg::*;
#(
    parameter int B = SAMPLE_W,
    parameter int L = NUM_LANES,
    parameter int N = ADDR_W
);

    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic [B-1:0]   s_axis_tdata;
    logic           s_axis_tlast;
    logic           mem_we;
    logic [N-1:0]   mem_addr;
    logic [L*B-1:0] mem_di;

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        input  s_axis_tready, mem_we, mem_addr, mem_di
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        output s_axis_tready, mem_we, mem_addr, mem_di
    );

endinterface

// File: rtl/qbuff_loader_lane_packer.sv
// Collects consecutive samples into lanes 0..L-1 of one packed word.
// word_ready is the registered one-cycle strobe that marks the word as complete.
module lane_packer
    import qbuff_pkg::*;
#(
    parameter int B  = SAMPLE_W,
    parameter int L  = NUM_LANES,
    parameter int LW = LANE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                accept,
    input  logic                last,
    input  logic [B-1:0]        data,
    output logic                word_end,
    output logic                word_ready,
    output logic [L-1:0][B-1:0] word
);

    logic [LW-1:0] lane;

    assign word_end = accept && (last || (lane == LW'(L - 1)));

    // Writing lane k also clears every lane above it, so short final words come out zero-filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane       <= '0;
            word       <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= word_end;
            if (clear) begin
                lane <= '0;
                word <= '0;
            end else if (accept) begin
                for (int i = 0; i < L; i++) begin
                    if (i == int'(lane)) begin
                        word[i] <= data;
                    end else if (i > int'(lane)) begin
                        word[i] <= '0;
                    end
                end
                lane <= word_end ? '0 : lane + 1'b1;
            end
        end
    end

endmodule

// File: rtl/qbuff_loader.sv
// Loads a serial sample stream into the lane memories, L samples per address.
// Owns the load FSM, the arm edge detector, the address/word counters and status.
module qbuff_loader
    import qbuff_pkg::*;
#(
    parameter int B = SAMPLE_W,
    parameter int L = NUM_LANES,
    parameter int N = ADDR_W
) (
    input  logic          aclk,
    input  logic          aresetn,
    qbuff_loader_if.slave bus,
    input  logic          START_REG,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [N:0]    nwords
);

    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam logic [N:0] LAST_SLOT = {1'b0, {N{1'b1}}};

    state_t              state;
    state_t              next_state;
    logic                start_prev;
    logic                arm;
    logic                tready;
    logic                accept;
    logic                word_end;
    logic                word_ready;
    logic [N:0]          wcount;
    logic [N-1:0]        addr;
    logic [L-1:0][B-1:0] word;

    assign arm               = START_REG && !start_prev && (state == IDLE || state == DONE);
    assign accept            = bus.s_axis_tvalid && tready;
    assign bus.s_axis_tready = tready;
    assign bus.mem_we        = word_ready;
    assign bus.mem_addr      = addr;
    assign bus.mem_di        = word;

    lane_packer #(.B(B), .L(L), .LW(LW)) u_packer (
        .clk        (aclk),
        .rst_n      (aresetn),
        .clear      (arm),
        .accept     (accept && state == LOAD),
        .last       (bus.s_axis_tlast),
        .data       (bus.s_axis_tdata),
        .word_end   (word_end),
        .word_ready (word_ready),
        .word       (word)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // tlast wins over the full condition, so an exactly-full load ends cleanly without ovf.
    always_comb begin
        next_state = state;
        tready     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm) next_state = LOAD;
            end
            LOAD: begin
                tready = 1'b1;
                busy   = 1'b1;
                if (word_end && bus.s_axis_tlast) begin
                    next_state = DONE;
                end else if (word_end && wcount == LAST_SLOT) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                tready = 1'b1;
                busy   = 1'b1;
                if (accept && bus.s_axis_tlast) next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (arm) next_state = LOAD;
            end
        endcase
    end

    // addr latches the slot of the word being finished so it lines up with the mem_we pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            start_prev <= 1'b0;
            wcount     <= '0;
            addr       <= '0;
            nwords     <= '0;
            ovf        <= 1'b0;
        end else begin
            start_prev <= START_REG;
            if (arm) begin
                wcount <= '0;
                addr   <= '0;
                nwords <= '0;
                ovf    <= 1'b0;
            end else if (word_end) begin
                addr   <= wcount[N-1:0];
                wcount <= wcount + 1'b1;
                nwords <= wcount + 1'b1;
                if (!bus.s_axis_tlast && wcount == LAST_SLOT) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qbuff_loader.sv
// Randomized bench for qbuff_loader: every write is checked against a word list
// derived directly from the sample sequence, lane count and memory depth.
module tb_qbuff_loader;
    import qbuff_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    typedef struct {
        logic [ADDR_W-1:0]             addr;
        logic [NUM_LANES*SAMPLE_W-1:0] di;
        logic                          ovf;
        logic [ADDR_W:0]               nw;
    } wr_t;

    logic            aclk;
    logic            aresetn;
    logic            start_reg;
    logic            busy;
    logic            done;
    logic            ovf;
    logic [ADDR_W:0] nwords;

    int          checks;
    int          failures;
    wr_t         wr_q[$];
    logic [7:0]  smp[0:127];

    qbuff_loader_if #(.B(SAMPLE_W), .L(NUM_LANES), .N(ADDR_W)) bus ();

    qbuff_loader #(.B(SAMPLE_W), .L(NUM_LANES), .N(ADDR_W)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .bus       (bus),
        .START_REG (start_reg),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .nwords    (nwords)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Every memory write seen mid-cycle is logged together with the status beside it.
    always @(negedge aclk) begin
        if (bus.mem_we === 1'b1) begin
            wr_q.push_back('{bus.mem_addr, bus.mem_di, ovf, nwords});
        end
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        bit acc;
        acc = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        for (int c = 0; c < 64 && !acc; c++) begin
            acc = bus.s_axis_tready;
            step();
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        if (!acc) check_output("beat_timeout", 0, 1);
    endtask

    task automatic arm();
        start_reg = 1'b1;
        step();
        start_reg = 1'b0;
        check_output("arm_busy", busy, 1);
        check_output("arm_done", done, 0);
        check_output("arm_ovf", ovf, 0);
        check_output("arm_nwords", nwords, 0);
        wr_q.delete();
    endtask

    task automatic apply_stimulus(input int n, input int gap_max, input bit poke_start);
        int g;
        for (int k = 0; k < n; k++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) step();
            if (poke_start && k == n / 2) begin
                start_reg = 1'b1;
                step();
                start_reg = 1'b0;
            end
            if (k == n - 1) begin
                check_output("pre_last_busy", busy, 1);
                check_output("pre_last_done", done, 0);
                check_output("pre_last_ovf", ovf, (n - 1 >= DEPTH * NUM_LANES) ? 1 : 0);
            end
            send_beat(smp[k], k == n - 1);
        end
        repeat (3) step();
    endtask

    // Expected writes: samples chunked L at a time, capped at DEPTH words, short tail zero-filled.
    task automatic check_load(input int n);
        int         total;
        int         nwr;
        bit         exp_ovf;
        lane_word_t w;
        total   = (n + NUM_LANES - 1) / NUM_LANES;
        exp_ovf = total > DEPTH;
        nwr     = exp_ovf ? DEPTH : total;
        check_output("write_count", wr_q.size(), nwr);
        for (int wi = 0; wi < nwr && wi < wr_q.size(); wi++) begin
            w = '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wi * NUM_LANES + i < n) w[i] = smp[wi * NUM_LANES + i];
            end
            check_output("wr_addr", wr_q[wi].addr, wi);
            check_output("wr_data", wr_q[wi].di, w);
            check_output("wr_ovf", wr_q[wi].ovf, (exp_ovf && wi == nwr - 1) ? 1 : 0);
            check_output("wr_nwords", wr_q[wi].nw, wi + 1);
        end
        check_output("end_done", done, 1);
        check_output("end_ovf", ovf, exp_ovf);
        check_output("end_nwords", nwords, nwr);
        check_output("end_tready", bus.s_axis_tready, 0);
        check_output("end_busy", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_tready"}, bus.s_axis_tready, 0);
        check_output({tag, "_we"}, bus.mem_we, 0);
        check_output({tag, "_addr"}, bus.mem_addr, 0);
        check_output({tag, "_di"}, bus.mem_di, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_ovf"}, ovf, 0);
        check_output({tag, "_nwords"}, nwords, 0);
    endtask

    initial begin
        int n;
        checks            = 0;
        failures          = 0;
        aresetn           = 1'b0;
        start_reg         = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        aresetn = 1'b1;
        step();

        // Beats offered while idle must be refused and never reach memory.
        bus.s_axis_tvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.s_axis_tdata = 8'(k + 1);
            bus.s_axis_tlast = (k == 4);
            check_output("idle_tready", bus.s_axis_tready, 0);
            step();
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        step();
        check_output("idle_writes", wr_q.size(), 0);

        $display("[TB] full word load");
        for (int k = 0; k < 8; k++) smp[k] = 8'(k + 1);
        arm();
        apply_stimulus(8, 0, 1'b0);
        check_load(8);

        $display("[TB] partial final word");
        smp[0] = 8'hA1; smp[1] = 8'hA2; smp[2] = 8'hA3;
        smp[3] = 8'hA4; smp[4] = 8'hB1; smp[5] = 8'hB2;
        arm();
        apply_stimulus(6, 0, 1'b0);
        check_load(6);

        $display("[TB] overflow");
        for (int k = 0; k < 70; k++) smp[k] = 8'($urandom);
        arm();
        apply_stimulus(70, 0, 1'b0);
        check_load(70);

        $display("[TB] gaps with ignored start edge");
        for (int k = 0; k < 8; k++) smp[k] = 8'(k + 1);
        arm();
        apply_stimulus(8, 3, 1'b1);
        check_load(8);

        $display("[TB] random loads");
        for (int r = 0; r < 8; r++) begin
            n = (r == 0) ? DEPTH * NUM_LANES : int'($urandom_range(75, 1));
            for (int k = 0; k < n; k++) smp[k] = 8'($urandom);
            arm();
            apply_stimulus(n, 2, r[0]);
            check_load(n);
        end

        $display("[TB] reset mid-load");
        for (int k = 0; k < 6; k++) smp[k] = 8'($urandom);
        start_reg = 1'b1;
        step();
        wr_q.delete();
        for (int k = 0; k < 6; k++) send_beat(smp[k], 1'b0);
        step();
        aresetn = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) step();
        check_output("midrst_writes", wr_q.size(), 1);
        if (wr_q.size() > 0) check_output("midrst_word0", wr_q[0].di, {smp[3], smp[2], smp[1], smp[0]});
        aresetn = 1'b1;
        step();
        check_output("post_rst_arm_busy", busy, 1);
        check_output("post_rst_nwords", nwords, 0);
        wr_q.delete();
        send_beat(8'h5A, 1'b1);
        repeat (3) step();
        check_output("post_rst_writes", wr_q.size(), 1);
        if (wr_q.size() > 0) check_output("post_rst_word", wr_q[0].di, 32'h0000005A);
        check_output("post_rst_done", done, 1);
        repeat (3) step();
        check_output("held_high_no_rearm", done, 1);
        start_reg = 1'b0;
        step();
        start_reg = 1'b1;
        step();
        check_output("rearm_busy", busy, 1);
        check_output("rearm_done", done, 0);
        send_beat(8'h11, 1'b1);
        start_reg = 1'b0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
